lockstep_scoreboard: RTL and testbench

Multi-channel lockstep comparator for co-simulating a master model (RTL) against a slave model (behavioural). Each channel buffers master snapshots in a FIFO, pops one whenever the slave reports the same event, and compares the two under a per-channel mask. Errors are reported with channel, expected and actual values. Overflow and underflow are flagged, and the block can freeze on the first error. It generalises the per-stream snapshot-buffer checks used across the cache co-simulation benches (icache, dcache, write buffer, register file) into one parametrised block.

---
 rtl/scb_pkg.sv | 22 ++
 rtl/scb_fifo.sv | 66 ++++++
 rtl/lockstep_scoreboard.sv | 151 +++++++++++++++
 tb/tb_lockstep_scoreboard.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scb_pkg.sv
// rtl/scb_pkg.sv - shared state, error codes and counter helpers for the lockstep scoreboard
package scb_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [1:0] ERR_MISMATCH  = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/scb_fifo.sv
// rtl/scb_fifo.sv - per-channel snapshot buffer with empty bypass
// rd_data is the value a pop compares against: the tail entry, or the incoming word when empty.
module scb_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      level_q, level_d;
  logic             bypass, do_wr, do_rd;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign level   = level_q;
  assign rd_data = empty ? wr_data : mem_q[tail_q];

  always_comb begin
    bypass  = empty & push & pop;
    do_rd   = pop & ~empty;
    // when full, a push is only accepted if the same cycle frees the tail slot
    do_wr   = push & ~bypass & (~full | pop);
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (do_wr) head_d = head_q + 1'b1;
      if (do_rd) tail_d = tail_q + 1'b1;
      level_d = level_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clr && do_wr) mem_q[head_q] <= wr_data;
  end

endmodule

// File: rtl/lockstep_scoreboard.sv
// rtl/lockstep_scoreboard.sv - multi-channel lockstep comparator of master vs slave snapshots
// Per-channel FIFOs feed a masked compare; errors are priority-encoded by lowest channel.
module lockstep_scoreboard
  import scb_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 100,
  parameter int DEPTH       = 32,
  parameter int AW          = 5,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [CHANNELS-1:0]          exp_valid,
  input  logic [CHANNELS*WIDTH-1:0]    exp_data,
  input  logic [CHANNELS-1:0]          act_valid,
  input  logic [CHANNELS*WIDTH-1:0]    act_data,
  input  logic [CHANNELS*WIDTH-1:0]    cmp_mask,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [$clog2(CHANNELS)-1:0]  err_ch,
  output logic [WIDTH-1:0]             err_exp,
  output logic [WIDTH-1:0]             err_act,
  output logic                         halted,
  output logic [CNT_W-1:0]             err_count,
  output logic [CHANNELS*CNT_W-1:0]    match_count,
  output logic [CHANNELS*(AW+1)-1:0]   level
);

  localparam int CW = $clog2(CHANNELS);

  state_e           state_q, state_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CW-1:0]    err_ch_q, err_ch_d;
  logic [WIDTH-1:0] err_exp_q, err_exp_d;
  logic [WIDTH-1:0] err_act_q, err_act_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] match_count_q [CHANNELS];
  logic [CNT_W-1:0] match_count_d [CHANNELS];
  logic [CNT_W-1:0] nerr;

  logic                run;
  logic [CHANNELS-1:0] push, pop, full, empty, ovf, unf, mis, hit;
  logic [WIDTH-1:0]    rd_data [CHANNELS];

  assign run = (state_q == RUN);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign push[c] = exp_valid[c] & run;
    assign pop[c]  = act_valid[c] & run;

    scb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr     (clear),
      .push    (push[c]),
      .pop     (pop[c]),
      .wr_data (exp_data[c*WIDTH +: WIDTH]),
      .rd_data (rd_data[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .level   (level[c*(AW+1) +: AW+1])
    );

    assign ovf[c] = push[c] & ~pop[c] & full[c];
    assign unf[c] = pop[c] & ~push[c] & empty[c];
    assign mis[c] = pop[c] & ~unf[c] &
                    (|((rd_data[c] ^ act_data[c*WIDTH +: WIDTH]) & cmp_mask[c*WIDTH +: WIDTH]));
    assign hit[c] = pop[c] & ~unf[c] & ~mis[c];

    assign match_count[c*CNT_W +: CNT_W] = match_count_q[c];
  end

  always_comb begin
    state_d       = state_q;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;
    err_ch_d      = err_ch_q;
    err_exp_d     = err_exp_q;
    err_act_d     = err_act_q;
    match_count_d = match_count_q;
    nerr          = '0;
    // descending scan so the lowest erroring channel is the one left in the report
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (ovf[c] || unf[c] || mis[c]) begin
        err_valid_d = 1'b1;
        err_ch_d    = CW'(c);
        nerr        = nerr + 1'b1;
        if (ovf[c]) begin
          err_code_d = ERR_OVERFLOW;
          err_exp_d  = '0;
          err_act_d  = '0;
        end else if (unf[c]) begin
          err_code_d = ERR_UNDERFLOW;
          err_exp_d  = '0;
          err_act_d  = '0;
        end else begin
          err_code_d = ERR_MISMATCH;
          err_exp_d  = rd_data[c];
          err_act_d  = act_data[c*WIDTH +: WIDTH];
        end
      end
      if (hit[c]) match_count_d[c] = sat_add(match_count_q[c], CNT_W'(1));
    end
    err_count_d = sat_add(err_count_q, nerr);
    if (err_valid_d && (STOP_ON_ERR != 0)) state_d = HALT;
    if (clear) begin
      state_d       = RUN;
      err_valid_d   = 1'b0;
      err_code_d    = '0;
      err_ch_d      = '0;
      err_exp_d     = '0;
      err_act_d     = '0;
      err_count_d   = '0;
      match_count_d = '{default: '0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RUN;
      err_valid_q   <= 1'b0;
      err_code_q    <= '0;
      err_ch_q      <= '0;
      err_exp_q     <= '0;
      err_act_q     <= '0;
      err_count_q   <= '0;
      match_count_q <= '{default: '0};
    end else begin
      state_q       <= state_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      err_ch_q      <= err_ch_d;
      err_exp_q     <= err_exp_d;
      err_act_q     <= err_act_d;
      err_count_q   <= err_count_d;
      match_count_q <= match_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_ch    = err_ch_q;
  assign err_exp   = err_exp_q;
  assign err_act   = err_act_q;
  assign err_count = err_count_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_lockstep_scoreboard.sv
// tb/tb_lockstep_scoreboard.sv - scoreboard-driven bench for lockstep_scoreboard
module tb_lockstep_scoreboard;

  localparam int CH = 4;
  localparam int W  = 100;
  localparam int D  = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clear = 1'b0;
  logic [CH-1:0]   exp_valid = '0;
  logic [CH*W-1:0] exp_data = '0;
  logic [CH-1:0]   act_valid = '0;
  logic [CH*W-1:0] act_data = '0;
  logic [CH*W-1:0] mask = '1;
  logic            err_valid;
  logic [1:0]      err_code;
  logic [1:0]      err_ch;
  logic [W-1:0]    err_exp, err_act;
  logic            halted;
  logic [15:0]     err_count;
  logic [CH*16-1:0]     match_count;
  logic [CH*(AW+1)-1:0] level;

  lockstep_scoreboard #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .AW(AW), .STOP_ON_ERR(1)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data), .cmp_mask(mask),
    .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
    .err_exp(err_exp), .err_act(err_act), .halted(halted),
    .err_count(err_count), .match_count(match_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   code;
    logic [1:0]   ch;
    logic [W-1:0] e;
    logic [W-1:0] a;
  } err_t;

  err_t         err_q[$];
  logic [W-1:0] sb [CH][$];
  int           mc_m [CH];
  int           errc_m;
  bit           halt_m;
  int           passed = 0;
  int           total = 0;

  function automatic logic [W-1:0] pat(input int i);
    logic [W-1:0] base;
    base = {4'h0, {12{8'hA5}}};
    return base ^ W'(i);
  endfunction

  // Drive one cycle at the falling edge, advance the reference model, sample after the next edge.
  task automatic cycle(input logic [CH-1:0] ev, input logic [CH-1:0] av,
                       input logic [CH*W-1:0] ed, input logic [CH*W-1:0] ad);
    logic [W-1:0] e, a, front;
    bit got, has_err, was_empty;
    err_t rec, r;
    int nerr;
    exp_valid = ev; act_valid = av; exp_data = ed; act_data = ad;
    got = 0; nerr = 0;
    rec = '{code: 2'd0, ch: 2'd0, e: '0, a: '0};
    if (!rst || clear) begin
      for (int c = 0; c < CH; c++) begin sb[c].delete(); mc_m[c] = 0; end
      errc_m = 0; halt_m = 0; err_q.delete();
    end else if (!halt_m) begin
      for (int c = 0; c < CH; c++) begin
        e = ed[c*W +: W]; a = ad[c*W +: W];
        has_err = 0;
        r = '{code: 2'd0, ch: 2'(c), e: '0, a: '0};
        was_empty = (sb[c].size() == 0);
        if (av[c]) begin
          if (was_empty && !ev[c]) begin
            has_err = 1; r.code = 2'd2;
          end else begin
            front = was_empty ? e : sb[c].pop_front();
            if (((front ^ a) & mask[c*W +: W]) != '0) begin
              has_err = 1; r.code = 2'd0; r.e = front; r.a = a;
            end else mc_m[c]++;
            if (ev[c] && !was_empty) sb[c].push_back(e);
          end
        end else if (ev[c]) begin
          if (sb[c].size() == D) begin has_err = 1; r.code = 2'd1; end
          else sb[c].push_back(e);
        end
        if (has_err) begin
          nerr++;
          if (!got) begin got = 1; rec = r; end
        end
      end
      errc_m += nerr;
      if (got) begin err_q.push_back(rec); halt_m = 1; end
    end
    @(posedge clk);
    @(negedge clk);
    exp_valid = '0; act_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle('0, '0, '0, '0);
    cycle('0, '0, '0, '0);
    rst = 1'b1;
    mask = '1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid got=%b want=0", err_valid); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b want=0", halted); else passed++;
    total++; if (err_count !== 16'd0) $display("FAIL reset_err_count got=%0d want=0", err_count); else passed++;
    total++; if (level !== '0 || match_count !== '0) $display("FAIL reset_level_match got=%h/%h want=0", level, match_count); else passed++;
  endtask

  task automatic test_lockstep_match();
    logic [CH*W-1:0] v;
    do_reset();
    for (int i = 0; i < 10; i++) begin v = '0; v[W-1:0] = pat(i); cycle(4'b0001, '0, v, '0); end
    total++; if (level[AW:0] !== 6'd10) $display("FAIL match_level_full got=%0d want=10", level[AW:0]); else passed++;
    for (int i = 0; i < 3; i++) cycle('0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      v = '0; v[W-1:0] = pat(i);
      cycle('0, 4'b0001, '0, v);
      total++; if (err_valid !== 1'b0 || err_q.size() != 0) $display("FAIL match_pop%0d err_valid got=%b want=0", i, err_valid); else passed++;
    end
    total++; if (match_count[15:0] !== 16'(mc_m[0]) || mc_m[0] != 10) $display("FAIL match_count got=%0d want=10", match_count[15:0]); else passed++;
    total++; if (err_count !== 16'd0 || level[AW:0] !== 6'd0) $display("FAIL match_final got=%0d/%0d want=0/0", err_count, level[AW:0]); else passed++;
  endtask

  task automatic test_masked_mismatch();
    logic [CH*W-1:0] e1, a3;
    err_t x;
    do_reset();
    e1 = '0; e1[0] = 1'b1;
    a3 = '0; a3[1:0] = 2'b11;
    mask[1] = 1'b0;
    cycle(4'b0001, '0, e1, '0);
    cycle('0, 4'b0001, '0, a3);
    total++; if (err_valid !== 1'b0 || match_count[15:0] !== 16'd1) $display("FAIL masked_ok got=%b/%0d want=0/1", err_valid, match_count[15:0]); else passed++;
    mask[1] = 1'b1;
    cycle(4'b0001, '0, e1, '0);
    cycle('0, 4'b0001, '0, a3);
    if (err_q.size() == 0) begin
      total++; $display("FAIL masked_sb_empty got=0 want=1 entry");
    end else begin
      x = err_q.pop_front();
      total++; if (err_valid !== 1'b1 || err_code !== x.code || err_ch !== x.ch) $display("FAIL mismatch_report got=%b/%0d/%0d want=1/%0d/%0d", err_valid, err_code, err_ch, x.code, x.ch); else passed++;
      total++; if (err_exp !== x.e || err_act !== x.a) $display("FAIL mismatch_operands got=%h/%h want=%h/%h", err_exp, err_act, x.e, x.a); else passed++;
    end
    total++; if (halted !== 1'b1) $display("FAIL mismatch_halted got=%b want=1", halted); else passed++;
    cycle(4'b0001, '0, e1, '0);
    total++; if (err_valid !== 1'b0 || halted !== 1'b1 || err_exp !== W'(1)) $display("FAIL halt_hold got=%b/%b/%h want=0/1/1", err_valid, halted, err_exp); else passed++;
    total++; if (level[AW:0] !== 6'(sb[0].size())) $display("FAIL halt_push_ignored got=%0d want=%0d", level[AW:0], sb[0].size()); else passed++;
  endtask

  task automatic test_overflow_wrap();
    logic [CH*W-1:0] v;
    int bad;
    err_t x;
    do_reset();
    for (int i = 0; i < D; i++) begin v = '0; v[2*W +: W] = {$urandom, $urandom, $urandom, $urandom}; cycle(4'b0100, '0, v, '0); end
    total++; if (level[2*(AW+1) +: AW+1] !== 6'd32) $display("FAIL ovf_fill_level got=%0d want=32", level[2*(AW+1) +: AW+1]); else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin v = '0; v[2*W +: W] = sb[2][0]; cycle('0, 4'b0100, '0, v); if (err_valid !== 1'b0) bad++; end
    for (int i = 0; i < 16; i++) begin v = '0; v[2*W +: W] = {$urandom, $urandom, $urandom, $urandom}; cycle(4'b0100, '0, v, '0); end
    for (int i = 0; i < D; i++) begin v = '0; v[2*W +: W] = sb[2][0]; cycle('0, 4'b0100, '0, v); if (err_valid !== 1'b0) bad++; end
    total++; if (bad != 0 || match_count[2*16 +: 16] !== 16'(mc_m[2])) $display("FAIL wrap_order errors=%0d matches=%0d want=0/%0d", bad, match_count[2*16 +: 16], mc_m[2]); else passed++;
    for (int i = 0; i < D; i++) begin v = '0; v[2*W +: W] = W'(i); cycle(4'b0100, '0, v, '0); end
    v = '0; v[2*W +: W] = W'(99);
    cycle(4'b0100, '0, v, '0);
    if (err_q.size() == 0) begin
      total++; $display("FAIL ovf_sb_empty got=0 want=1 entry");
    end else begin
      x = err_q.pop_front();
      total++; if (err_valid !== 1'b1 || err_code !== x.code || err_ch !== x.ch || err_exp !== '0) $display("FAIL ovf_report got=%b/%0d/%0d want=1/%0d/%0d", err_valid, err_code, err_ch, x.code, x.ch); else passed++;
    end
    total++; if (level[2*(AW+1) +: AW+1] !== 6'd32) $display("FAIL ovf_level got=%0d want=32", level[2*(AW+1) +: AW+1]); else passed++;
  endtask

  task automatic test_bypass();
    logic [CH*W-1:0] v, a;
    do_reset();
    v = '0; v[W +: W] = W'(5);
    cycle(4'b0010, 4'b0010, v, v);
    total++; if (err_valid !== 1'b0 || level[(AW+1) +: AW+1] !== 6'd0 || match_count[16 +: 16] !== 16'd1) $display("FAIL bypass got=%b/%0d/%0d want=0/0/1", err_valid, level[(AW+1) +: AW+1], match_count[16 +: 16]); else passed++;
    for (int i = 0; i < D; i++) begin v = '0; v[W +: W] = W'(i + 100); cycle(4'b0010, '0, v, '0); end
    v = '0; v[W +: W] = W'(7);
    a = '0; a[W +: W] = sb[1][0];
    cycle(4'b0010, 4'b0010, v, a);
    total++; if (err_valid !== 1'b0 || level[(AW+1) +: AW+1] !== 6'd32 || match_count[16 +: 16] !== 16'd2) $display("FAIL full_pushpop got=%b/%0d/%0d want=0/32/2", err_valid, level[(AW+1) +: AW+1], match_count[16 +: 16]); else passed++;
  endtask

  task automatic test_concurrent();
    logic [CH*W-1:0] v, a;
    err_t x;
    do_reset();
    v = '0; v[W +: W] = W'(119);
    cycle(4'b0010, '0, v, '0);
    a = '0; a[W +: W] = W'(118); a[3*W +: W] = W'(1);
    cycle('0, 4'b1010, '0, a);
    if (err_q.size() == 0) begin
      total++; $display("FAIL conc_sb_empty got=0 want=1 entry");
    end else begin
      x = err_q.pop_front();
      total++; if (err_ch !== x.ch || err_code !== x.code || err_exp !== x.e) $display("FAIL conc_report got=%0d/%0d want=%0d/%0d", err_ch, err_code, x.ch, x.code); else passed++;
    end
    total++; if (err_count !== 16'(errc_m) || errc_m != 2) $display("FAIL conc_err_count got=%0d want=2", err_count); else passed++;
  endtask

  task automatic test_reset_clear();
    logic [CH*W-1:0] v;
    err_t x;
    do_reset();
    for (int i = 0; i < 6; i++) begin v = '0; v[W-1:0] = pat(i); cycle(4'b0001, '0, v, '0); end
    v = '0; v[W-1:0] = pat(0);
    cycle('0, 4'b0001, '0, v);
    total++; if (match_count[15:0] !== 16'd1 || level[AW:0] !== 6'd5) $display("FAIL pre_reset got=%0d/%0d want=1/5", match_count[15:0], level[AW:0]); else passed++;
    rst = 1'b0;
    v[W-1:0] = ~pat(1);
    cycle('0, 4'b0001, '0, v);
    rst = 1'b1;
    total++; if (err_valid !== 1'b0 || halted !== 1'b0 || level !== '0 || match_count !== '0 || err_count !== '0) $display("FAIL midrun_reset got=%b/%b/%h/%h want=0/0/0/0", err_valid, halted, level, match_count); else passed++;
    cycle('0, 4'b0001, '0, '0);
    if (err_q.size() == 0) begin
      total++; $display("FAIL unf_sb_empty got=0 want=1 entry");
    end else begin
      x = err_q.pop_front();
      total++; if (err_code !== x.code || halted !== 1'b1 || err_count !== 16'(errc_m)) $display("FAIL underflow got=%0d/%b/%0d want=%0d/1/%0d", err_code, halted, err_count, x.code, errc_m); else passed++;
    end
    clear = 1'b1;
    v = '0; v[W-1:0] = pat(3);
    cycle(4'b0001, '0, v, '0);
    clear = 1'b0;
    total++; if (halted !== 1'b0 || err_count !== 16'd0 || err_code !== 2'd0 || level !== '0 || err_valid !== 1'b0) $display("FAIL clear got=%b/%0d/%0d/%h want=0/0/0/0", halted, err_count, err_code, level); else passed++;
  endtask

  initial begin
    errc_m = 0; halt_m = 0;
    for (int c = 0; c < CH; c++) mc_m[c] = 0;
    @(negedge clk);
    test_reset();
    test_lockstep_match();
    test_masked_mismatch();
    test_overflow_wrap();
    test_bypass();
    test_concurrent();
    test_reset_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
